// File: rtl/coin_pkg.sv
// Shared types for the coin acceptor front end.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } acc_state_t;

    typedef enum logic {
        NICKEL = 1'b0,
        DIME   = 1'b1
    } coin_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic Clk,
    input  logic Reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Synchronizes and debounces the nickel/dime sensors into single-cycle N, D or reject pulses.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic nickel_raw,
    input  logic dime_raw,
    input  logic accept_en,
    output logic N,
    output logic D,
    output logic reject,
    output logic busy
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic sn;
    logic sd;

    acc_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    coin_t           type_q, type_d;
    logic            n_q, n_d;
    logic            d_q, d_d;
    logic            rej_q, rej_d;

    logic sel_line;
    logic other_line;

    sync_2ff u_sync_nickel (
        .Clk   (Clk),
        .Reset (Reset),
        .d_i   (nickel_raw),
        .q_o   (sn)
    );

    sync_2ff u_sync_dime (
        .Clk   (Clk),
        .Reset (Reset),
        .d_i   (dime_raw),
        .q_o   (sd)
    );

    assign sel_line   = (type_q == DIME) ? sd : sn;
    assign other_line = (type_q == DIME) ? sn : sd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        n_d     = 1'b0;
        d_d     = 1'b0;
        rej_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sn && sd) begin
                    state_d = WAIT_RELEASE;
                    rej_d   = 1'b1;
                end else if (sn || sd) begin
                    state_d = DEBOUNCE;
                    type_d  = sd ? DIME : NICKEL;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (sel_line && !other_line) begin
                    if (cnt_q == CntLast) begin
                        // Pulse is registered so it appears exactly while in EMIT.
                        state_d = EMIT;
                        if (accept_en) begin
                            n_d = (type_q == NICKEL);
                            d_d = (type_q == DIME);
                        end else begin
                            rej_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!sn && !sd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            type_q  <= NICKEL;
            n_q     <= 1'b0;
            d_q     <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            n_q     <= n_d;
            d_q     <= d_d;
            rej_q   <= rej_d;
        end
    end

    assign N      = n_q;
    assign D      = d_q;
    assign reject = rej_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed and randomized checks of coin_acceptor against a cycle-level reference model.
module tb_coin_acceptor;

    localparam int DC = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic nickel_raw = 1'b0;
    logic dime_raw = 1'b0;
    logic accept_en = 1'b1;
    logic N, D, reject, busy;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .nickel_raw (nickel_raw),
        .dime_raw   (dime_raw),
        .accept_en  (accept_en),
        .N          (N),
        .D          (D),
        .reject     (reject),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Reference model: raw lines delayed two samples, then a run-length rule.
    bit m_n1 = 0, m_n2 = 0, m_d1 = 0, m_d2 = 0;
    int m_phase = 0;    // 0 idle, 1 counting, 2 waiting release, 3 pulse cycle
    int m_run = 0;
    bit m_dime = 0;
    bit e_n = 0, e_d = 0, e_r = 0, e_busy = 0;

    int edge_no, first_edge, cnt_n, cnt_d, cnt_r, last_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at edge %0d (t=%0t)", tag, got, exp, edge_no, $time);
        end
    endtask

    task automatic model_step();
        bit sn, sd, mine, other;
        if (Reset) begin
            m_n1 = 0; m_n2 = 0; m_d1 = 0; m_d2 = 0;
            m_phase = 0; m_run = 0; m_dime = 0;
            e_n = 0; e_d = 0; e_r = 0;
        end else begin
            sn = m_n2;
            sd = m_d2;
            e_n = 0; e_d = 0; e_r = 0;
            case (m_phase)
                0: begin
                    if (sn && sd) begin
                        m_phase = 2;
                        e_r = 1;
                    end else if (sn || sd) begin
                        m_phase = 1;
                        m_dime = sd;
                        m_run = 0;
                    end
                end
                1: begin
                    mine  = m_dime ? sd : sn;
                    other = m_dime ? sn : sd;
                    if (mine && !other) begin
                        m_run++;
                        if (m_run == DC) begin
                            m_phase = 3;
                            if (accept_en) begin
                                e_n = !m_dime;
                                e_d = m_dime;
                            end else begin
                                e_r = 1;
                            end
                        end
                    end else begin
                        m_phase = 0;
                    end
                end
                3: m_phase = 2;
                default: if (!sn && !sd) m_phase = 0;
            endcase
            m_n2 = m_n1; m_n1 = nickel_raw;
            m_d2 = m_d1; m_d1 = dime_raw;
        end
        e_busy = (m_phase != 0);
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        edge_no++;
        @(negedge Clk);
        check("outs", 32'({N, D, reject, busy}), 32'({e_n, e_d, e_r, e_busy}));
        check("excl", 32'(int'(N) + int'(D) + int'(reject) <= 1), 32'd1);
        if (N) cnt_n++;
        if (D) cnt_d++;
        if (reject) cnt_r++;
        if (busy) last_busy = edge_no;
        if ((N || D || reject) && first_edge == 0) first_edge = edge_no;
    endtask

    task automatic begin_scn();
        nickel_raw = 0; dime_raw = 0; accept_en = 1; Reset = 0;
        repeat (4) cycle();
        edge_no = 0; first_edge = 0; cnt_n = 0; cnt_d = 0; cnt_r = 0; last_busy = 0;
    endtask

    initial begin
        int kind, len, gap;
        edge_no = 0;
        // Reset state
        Reset = 1;
        repeat (3) cycle();
        check("reset_outs", 32'({N, D, reject, busy}), 32'd0);

        // Nickel accepted
        begin_scn();
        nickel_raw = 1;
        repeat (10) cycle();
        nickel_raw = 0;
        repeat (8) cycle();
        check("nickel_edge", 32'(first_edge), 32'd7);
        check("nickel_cnt", 32'(cnt_n), 32'd1);
        check("nickel_other", 32'(cnt_d + cnt_r), 32'd0);
        check("nickel_idle", 32'(busy), 32'd0);

        // Glitch filtered
        begin_scn();
        dime_raw = 1;
        repeat (3) cycle();
        dime_raw = 0;
        repeat (3) cycle();
        check("glitch_pulses", 32'(cnt_n + cnt_d + cnt_r), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);

        // Reject while vending: accept_en low only at the sampling edge
        begin_scn();
        dime_raw = 1;
        repeat (6) cycle();
        accept_en = 0;
        cycle();
        accept_en = 1;
        repeat (3) cycle();
        dime_raw = 0;
        repeat (6) cycle();
        check("vend_edge", 32'(first_edge), 32'd7);
        check("vend_rej", 32'(cnt_r), 32'd1);
        check("vend_d", 32'(cnt_d + cnt_n), 32'd0);

        // Jam
        begin_scn();
        nickel_raw = 1; dime_raw = 1;
        repeat (6) cycle();
        nickel_raw = 0; dime_raw = 0;
        repeat (6) cycle();
        check("jam_edge", 32'(first_edge), 32'd3);
        check("jam_rej", 32'(cnt_r), 32'd1);
        check("jam_nd", 32'(cnt_n + cnt_d), 32'd0);

        // Held coin
        begin_scn();
        nickel_raw = 1;
        repeat (50) cycle();
        nickel_raw = 0;
        repeat (8) cycle();
        check("held_cnt", 32'(cnt_n), 32'd1);
        check("held_busy_end", 32'(last_busy), 32'd52);

        // Reset mid-debounce
        begin_scn();
        nickel_raw = 1;
        repeat (4) cycle();
        Reset = 1;
        cycle();
        check("rst_outs", 32'({N, D, reject, busy}), 32'd0);
        Reset = 0;
        nickel_raw = 0;
        repeat (8) cycle();
        check("rst_no_n", 32'(cnt_n + cnt_d + cnt_r), 32'd0);
        begin_scn();
        nickel_raw = 1;
        repeat (10) cycle();
        nickel_raw = 0;
        repeat (6) cycle();
        check("rst_next_edge", 32'(first_edge), 32'd7);
        check("rst_next_cnt", 32'(cnt_n), 32'd1);

        // Randomized coin traffic with sporadic resets
        begin_scn();
        for (int s = 0; s < 250; s++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 12);
            gap  = $urandom_range(0, 5);
            for (int c = 0; c < len + gap; c++) begin
                nickel_raw = (c < len) && (kind < 4 || kind == 8);
                dime_raw   = (c < len) && ((kind >= 4 && kind < 8) || kind == 8);
                accept_en  = ($urandom_range(0, 3) != 0);
                Reset      = ($urandom_range(0, 59) == 0);
                cycle();
            end
        end
        Reset = 0;
        nickel_raw = 0;
        dime_raw = 0;
        repeat (5) cycle();
        check("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage for the vending controller. It synchronizes and debounces the raw nickel and dime sensor lines and produces clean single-cycle N and D pulses for the downstream vending FSM. A coin inserted while the downstream FSM cannot take credit, or a jammed sensor pair, produces a single-cycle reject pulse for the coin-return actuator instead.

## Interface
- DEBOUNCE_CYCLES, 4, number of consecutive stable synchronized samples required before a coin is recognised; legal range ≥ 1.
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- nickel_raw  in  1  asynchronous nickel sensor; high while a coin is in the slot.
- dime_raw  in  1  asynchronous dime sensor; high while a coin is in the slot.
- accept_en  in  1  high when the downstream FSM can take credit; low while vending.
- N  out  1  one-cycle pulse for a recognised nickel.
- D  out  1  one-cycle pulse for a recognised dime.
- reject  out  1  one-cycle pulse that commands a coin return.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Each raw input passes through a 2-flop synchronizer. The synchronized lines are sn and sd.
- The FSM has four states: IDLE, DEBOUNCE, EMIT, WAIT_RELEASE.
- **IDLE**
  - Exactly one of sn or sd high: latch the coin type, clear the counter, go to DEBOUNCE.
  - Both high: go to WAIT_RELEASE and pulse reject (jam).
  - Neither high: stay in IDLE.
- **DEBOUNCE**
  - Each cycle the latched line is high and the other line is low, the counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and the lines are stable, sample accept_en and go to EMIT.
  - If the latched line drops, or the other line rises: go to IDLE with no pulse (glitch filtered).
- **EMIT** lasts exactly one cycle, then the FSM goes to WAIT_RELEASE.
  - accept_en was 1 at sampling: N or D is high, matching the latched type.
  - accept_en was 0 at sampling: reject is high.
- **WAIT_RELEASE**: stay until sn and sd are both low, then go to IDLE. A held coin therefore yields exactly one pulse.
- N, D and reject are registered and mutually exclusive. At most one of them is high in any cycle.
- The counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps, because it is cleared on entry to DEBOUNCE.
- Reset
  - Reset values: state IDLE, synchronizer flops 0, counter 0, latched type 0, N/D/reject/busy 0.
  - Reset mid-DEBOUNCE or in EMIT discards the coin. No pulse is emitted on or after the Reset cycle.
- Reset has priority over every transition.

## Timing
- Let edge k be the first rising edge that samples a raw line high.
  - Edge k+1: the synchronized line is high.
  - Edge k+2: FSM enters DEBOUNCE.
  - Edge k+2+DEBOUNCE_CYCLES: FSM enters EMIT.
  - The pulse is high in the cycle after edge k+2+DEBOUNCE_CYCLES.
- With the default of 4 and k=1, the pulse is high between edges 7 and 8.
- The raw line must be high at edges k through k+DEBOUNCE_CYCLES inclusive to be accepted.
- accept_en is sampled at edge k+2+DEBOUNCE_CYCLES. Its value at any other time has no effect.
- The jam reject pulse is high in the cycle after edge k+2.
- busy rises in the cycle after the IDLE exit edge. It falls in the cycle after the WAIT_RELEASE→IDLE edge.
- Minimum spacing between two coins on the same line: the line must be low for one synchronized sample so that WAIT_RELEASE exits.

## Structure
- The shared package coin_pkg holds:
  - typedef enum logic [1:0] acc_state_t (IDLE, DEBOUNCE, EMIT, WAIT_RELEASE);
  - typedef enum logic coin_t (NICKEL, DIME).
- One sub-module, sync_2ff: a single-bit 2-flop synchronizer with Reset. It is instantiated twice.
- The FSM, counter and output registers live in coin_acceptor.

## Test plan
- **Nickel accepted.** Stimulus: nickel_raw high for 10 cycles from edge 1, accept_en=1. Response: N high only between edges 7 and 8; D and reject stay 0; busy returns low after release.
- **Glitch filtered.** Stimulus: dime_raw high for 3 sampling edges, then low. Response: no N, D or reject; FSM back in IDLE; busy low within 6 cycles.
- **Reject while vending.** Stimulus: dime_raw held 10 cycles, accept_en=0 at edge 7. Response: reject pulses once between edges 7 and 8; D stays 0.
- **Jam.** Stimulus: nickel_raw and dime_raw rise together at edge 1. Response: reject pulses between edges 3 and 4; no N or D until both lines are low.
- **Held coin.** Stimulus: nickel_raw held 50 cycles. Response: exactly one N pulse; busy high until 3 cycles after release.
- **Reset mid-debounce.** Stimulus: Reset asserted at edge 5 during a nickel. Response: all outputs 0 from the cycle after edge 5; no N pulse; the next coin after release is accepted normally.
